// File: rtl/uart_frame_rx_pkg.sv
// Shared definitions for the oversampling multi-byte UART receiver:
// parity codes, receiver FSM states and the tick divider calculation.
package uart_frame_rx_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK
    } rx_state_t;

    // Rounded clocks per oversample tick, never below one.
    function automatic int calc_div(input int clk_fre, input int bps, input int os);
        int d;
        d = (clk_fre + (bps * os) / 2) / (bps * os);
        if (d < 1) d = 1;
        return d;
    endfunction

endpackage

// File: rtl/uart_frame_rx_os_byte_rx.sv
// Single-byte UART receiver: input synchroniser, oversample tick generator,
// 2-of-3 majority voter and the start/data/parity/stop/break state machine.
module uart_os_byte_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int BPS        = 115200,
    parameter int CLK_FRE    = 50_000_000,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    output logic [7:0] byte_data,
    output logic       byte_vld,
    output logic       byte_perr,
    output logic       byte_ferr,
    output logic       idle,
    output logic       start_edge
);

    localparam int DIV   = calc_div(CLK_FRE, BPS, OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  SAMP_A    = OS_W'(OVERSAMPLE / 2 - 2);
    localparam logic [OS_W-1:0]  SAMP_B    = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  SAMP_C    = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  SAMP_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    rx_state_t        state, state_next;
    logic             rxd_s1, rxd_s2, rxd_d;
    logic [DIV_W-1:0] div_cnt;
    logic [OS_W-1:0]  samp_cnt;
    logic             samp_a, samp_b;
    logic [7:0]       shift;
    logic [2:0]       bit_idx;
    logic             stop_idx;
    logic             perr_r, ferr_r;

    logic tick, vote, vote_tick, bit_end, exp_par;

    // Sample index k is taken on the tick that leaves samp_cnt at k-1,
    // so the third vote sample is the live synchronised line.
    assign tick      = (div_cnt == DIV_LAST);
    assign vote      = (samp_a & samp_b) | (samp_a & rxd_s2) | (samp_b & rxd_s2);
    assign vote_tick = tick && (samp_cnt == SAMP_C);
    assign bit_end   = tick && (samp_cnt == SAMP_LAST);
    assign exp_par   = (PARITY == PAR_ODD) ? ~^shift : ^shift;

    assign start_edge = (state == ST_IDLE) && rxd_d && !rxd_s2;
    assign idle       = (state == ST_IDLE);
    assign byte_data  = shift;
    assign byte_perr  = perr_r;

    always_comb begin
        state_next = state;
        byte_vld   = 1'b0;
        byte_ferr  = ferr_r;
        case (state)
            ST_IDLE:   if (start_edge) state_next = ST_START;
            ST_START: begin
                if (vote_tick && vote)  state_next = ST_IDLE;
                else if (bit_end)       state_next = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && bit_idx == 3'd7)
                    state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (bit_end) state_next = ST_STOP;
            // The byte is committed at the last stop mid-sample, which also
            // re-arms start detection half a bit early to tolerate baud skew.
            ST_STOP: begin
                if (vote_tick && stop_idx == STOP_LAST) begin
                    byte_vld   = 1'b1;
                    byte_ferr  = ferr_r | ~vote;
                    state_next = (ferr_r | ~vote) ? ST_BRK : ST_IDLE;
                end
            end
            ST_BRK:    if (rxd_s2) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_IDLE;
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_d    <= 1'b1;
            div_cnt  <= '0;
            samp_cnt <= '0;
            samp_a   <= 1'b1;
            samp_b   <= 1'b1;
            shift    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            perr_r   <= 1'b0;
            ferr_r   <= 1'b0;
        end else begin
            rxd_s1 <= uart_rxd;
            rxd_s2 <= rxd_s1;
            rxd_d  <= rxd_s2;
            state  <= state_next;
            if (state == ST_IDLE) begin
                div_cnt  <= '0;
                samp_cnt <= '0;
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                perr_r   <= 1'b0;
                ferr_r   <= 1'b0;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                if (tick)
                    samp_cnt <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + OS_W'(1);
                if (tick && samp_cnt == SAMP_A) samp_a <= rxd_s2;
                if (tick && samp_cnt == SAMP_B) samp_b <= rxd_s2;
                if (vote_tick) begin
                    case (state)
                        ST_DATA:   shift  <= {vote, shift[7:1]};
                        ST_PARITY: perr_r <= (vote != exp_par);
                        ST_STOP:   ferr_r <= ferr_r | ~vote;
                        default:   ;
                    endcase
                end
                if (bit_end) begin
                    if (state == ST_DATA) bit_idx  <= bit_idx + 3'd1;
                    if (state == ST_STOP) stop_idx <= ~stop_idx;
                end
            end
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// Multi-byte UART frame receiver: packs BYTES received bytes big-endian into
// one word, tracks a sticky per-frame error and drops stale partial frames.
module uart_frame_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int BYTES        = 5,
    parameter int BPS          = 115200,
    parameter int CLK_FRE      = 50_000_000,
    parameter int OVERSAMPLE   = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               uart_rxd,
    output logic [BYTES*8-1:0] uart_bytes_data,
    output logic               uart_bytes_vld,
    output logic               uart_bytes_err,
    output logic               uart_bytes_tout
);

    localparam int DIV       = calc_div(CLK_FRE, BPS, OVERSAMPLE);
    localparam int CNT_W     = $clog2(BYTES + 1);
    localparam int TOUT_CLKS = TIMEOUT_BITS * OVERSAMPLE * DIV;
    localparam int TOUT_W    = $clog2(TOUT_CLKS + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BYTES - 1);
    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TOUT_CLKS - 1);

    logic [7:0]         byte_data;
    logic               byte_vld, byte_perr, byte_ferr, rx_idle, start_edge;
    logic [BYTES*8-1:0] frame_buf, frame_next;
    logic [CNT_W-1:0]   cnt;
    logic               sticky;
    logic [TOUT_W-1:0]  tout_cnt;
    logic               last_byte, byte_err, tout_run, tout_hit;

    uart_os_byte_rx #(
        .BPS        (BPS),
        .CLK_FRE    (CLK_FRE),
        .OVERSAMPLE (OVERSAMPLE),
        .PARITY     (PARITY),
        .STOP_BITS  (STOP_BITS)
    ) u_byte_rx (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .uart_rxd   (uart_rxd),
        .byte_data  (byte_data),
        .byte_vld   (byte_vld),
        .byte_perr  (byte_perr),
        .byte_ferr  (byte_ferr),
        .idle       (rx_idle),
        .start_edge (start_edge)
    );

    assign last_byte = (cnt == CNT_LAST);
    assign byte_err  = byte_perr | byte_ferr;
    assign tout_run  = rx_idle && (cnt != '0);
    // A start edge landing on the expiry cycle keeps the partial frame alive.
    assign tout_hit  = tout_run && !start_edge && (tout_cnt == TOUT_LAST);

    always_comb begin
        frame_next = frame_buf;
        frame_next[(BYTES - 1 - int'(cnt)) * 8 +: 8] = byte_data;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            uart_bytes_data <= '0;
            uart_bytes_vld  <= 1'b0;
            uart_bytes_err  <= 1'b0;
            uart_bytes_tout <= 1'b0;
            frame_buf       <= '0;
            cnt             <= '0;
            sticky          <= 1'b0;
            tout_cnt        <= '0;
        end else begin
            uart_bytes_vld  <= 1'b0;
            uart_bytes_err  <= 1'b0;
            uart_bytes_tout <= 1'b0;
            if (byte_vld) begin
                if (last_byte) begin
                    uart_bytes_data <= frame_next;
                    uart_bytes_vld  <= 1'b1;
                    uart_bytes_err  <= sticky | byte_err;
                    cnt             <= '0;
                    sticky          <= 1'b0;
                end else begin
                    frame_buf <= frame_next;
                    cnt       <= cnt + CNT_W'(1);
                    sticky    <= sticky | byte_err;
                end
            end else if (tout_hit) begin
                uart_bytes_tout <= 1'b1;
                cnt             <= '0;
                sticky          <= 1'b0;
            end
            if (start_edge || !tout_run || tout_hit)
                tout_cnt <= '0;
            else
                tout_cnt <= tout_cnt + TOUT_W'(1);
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: a no-parity and an even-parity instance
// are driven by a serial line model; a monitor checks every vld/tout pulse.
module tb_uart_frame_rx;

    localparam int CLK_FRE  = 50_000_000;
    localparam int BPS      = 781_250;
    localparam int BIT_CLKS = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rxd0, rxd2;
    logic [39:0] data0, data2;
    logic        vld0, err0, tout0, vld2, err2, tout2;

    typedef struct {
        logic [39:0] data;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];
    int   tout_exp0 = 0;
    int   tout_exp2 = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    always #10 clk = ~clk;

    uart_frame_rx #(
        .BYTES(5), .BPS(BPS), .CLK_FRE(CLK_FRE), .OVERSAMPLE(16),
        .PARITY(0), .STOP_BITS(1), .TIMEOUT_BITS(16)
    ) dut0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd0),
        .uart_bytes_data(data0), .uart_bytes_vld(vld0),
        .uart_bytes_err(err0), .uart_bytes_tout(tout0)
    );

    uart_frame_rx #(
        .BYTES(5), .BPS(BPS), .CLK_FRE(CLK_FRE), .OVERSAMPLE(16),
        .PARITY(2), .STOP_BITS(1), .TIMEOUT_BITS(16)
    ) dut2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd2),
        .uart_bytes_data(data2), .uart_bytes_vld(vld2),
        .uart_bytes_err(err2), .uart_bytes_tout(tout2)
    );

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic drive_bit(input int which, input logic v, input int clks);
        if (which == 0) rxd0 = v;
        else            rxd2 = v;
        repeat (clks) @(posedge clk);
    endtask

    task automatic send_byte(input int which, input logic [7:0] b, input int par_mode,
                             input logic par_bad, input logic stop_val, input int bclk);
        logic p;
        drive_bit(which, 1'b0, bclk);
        for (int i = 0; i < 8; i++) drive_bit(which, b[i], bclk);
        if (par_mode != 0) begin
            p = (par_mode == 1) ? ~^b : ^b;
            drive_bit(which, p ^ par_bad, bclk);
        end
        drive_bit(which, stop_val, bclk);
    endtask

    // Pushes the expected frame, then sends its five bytes; bad_idx selects a
    // byte to send with a corrupted parity bit (-1 for none).
    task automatic apply_stimulus(input int which, input logic [39:0] f, input logic err,
                                  input int par_mode, input int bad_idx, input int bclk);
        exp_t e;
        e.data = f;
        e.err  = err;
        if (which == 0) q0.push_back(e);
        else            q2.push_back(e);
        for (int i = 0; i < 5; i++)
            send_byte(which, f[39-8*i -: 8], par_mode, (i == bad_idx), 1'b1, bclk);
        drive_bit(which, 1'b1, 3 * BIT_CLKS);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (vld0) begin
                check_output("dut0 vld expected", 64'(q0.size() != 0), 64'd1);
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    check_output("dut0 data", 64'(data0), 64'(e.data));
                    check_output("dut0 err", 64'(err0), 64'(e.err));
                end
            end
            if (tout0) begin
                check_output("dut0 tout expected", 64'(tout_exp0 > 0), 64'd1);
                if (tout_exp0 > 0) tout_exp0--;
            end
            if (vld2) begin
                check_output("dut2 vld expected", 64'(q2.size() != 0), 64'd1);
                if (q2.size() != 0) begin
                    e = q2.pop_front();
                    check_output("dut2 data", 64'(data2), 64'(e.data));
                    check_output("dut2 err", 64'(err2), 64'(e.err));
                end
            end
            if (tout2) begin
                check_output("dut2 tout expected", 64'(tout_exp2 > 0), 64'd1);
                if (tout_exp2 > 0) tout_exp2--;
            end
        end
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        rxd0  = 1'b1;
        rxd2  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_output("reset data", 64'(data0), 64'd0);
        check_output("reset vld", 64'(vld0), 64'd0);
        check_output("reset err", 64'(err0), 64'd0);
        check_output("reset tout", 64'(tout0), 64'd0);
        rst_n = 1'b1;
        drive_bit(0, 1'b1, 2 * BIT_CLKS);

        // Back-to-back clean frame
        apply_stimulus(0, 40'h1122334455, 1'b0, 0, -1, BIT_CLKS);

        // Even parity: third byte carries a wrong parity bit, then a clean frame
        apply_stimulus(2, 40'h1234A55678, 1'b1, 2, 2, BIT_CLKS);
        apply_stimulus(2, 40'hCAFEBABE01, 1'b0, 2, -1, BIT_CLKS);

        // Partial frame dropped on inter-byte timeout
        tout_exp0 = 1;
        send_byte(0, 8'hAA, 0, 1'b0, 1'b1, BIT_CLKS);
        send_byte(0, 8'hBB, 0, 1'b0, 1'b1, BIT_CLKS);
        drive_bit(0, 1'b1, 20 * BIT_CLKS);
        check_output("tout fired", 64'(tout_exp0), 64'd0);
        apply_stimulus(0, 40'h0102030405, 1'b0, 0, -1, BIT_CLKS);

        // Short glitch low must be rejected as a false start
        drive_bit(0, 1'b0, 5);
        drive_bit(0, 1'b1, 2 * BIT_CLKS);
        apply_stimulus(0, 40'hDEADBEEF42, 1'b0, 0, -1, BIT_CLKS);

        // Framing error on the last byte followed by a break
        e.data = 40'h102030405A;
        e.err  = 1'b1;
        q0.push_back(e);
        for (int i = 0; i < 4; i++) send_byte(0, 8'h10 * 8'(i + 1), 0, 1'b0, 1'b1, BIT_CLKS);
        send_byte(0, 8'h5A, 0, 1'b0, 1'b0, BIT_CLKS);
        drive_bit(0, 1'b0, 12 * BIT_CLKS);
        drive_bit(0, 1'b1, 2 * BIT_CLKS);
        apply_stimulus(0, 40'h9876543210, 1'b0, 0, -1, BIT_CLKS);

        // Reset in the middle of the third byte
        send_byte(0, 8'h77, 0, 1'b0, 1'b1, BIT_CLKS);
        send_byte(0, 8'h88, 0, 1'b0, 1'b1, BIT_CLKS);
        drive_bit(0, 1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) drive_bit(0, (i == 0 || i == 3), BIT_CLKS);
        rst_n = 1'b0;
        #1;
        check_output("mid reset data", 64'(data0), 64'd0);
        check_output("mid reset vld", 64'(vld0), 64'd0);
        check_output("mid reset err", 64'(err0), 64'd0);
        check_output("mid reset tout", 64'(tout0), 64'd0);
        repeat (3) @(posedge clk);
        rxd0 = 1'b1;
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
        drive_bit(0, 1'b1, 2 * BIT_CLKS);
        apply_stimulus(0, 40'h0A0B0C0D0E, 1'b0, 0, -1, BIT_CLKS);

        // Sender baud skewed slow then fast
        apply_stimulus(0, 40'h1122334455, 1'b0, 0, -1, BIT_CLKS + 1);
        apply_stimulus(0, 40'h1122334455, 1'b0, 0, -1, BIT_CLKS - 1);

        drive_bit(0, 1'b1, 4 * BIT_CLKS);
        check_output("dut0 frames outstanding", 64'(q0.size()), 64'd0);
        check_output("dut2 frames outstanding", 64'(q2.size()), 64'd0);
        check_output("dut0 touts outstanding", 64'(tout_exp0), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
